// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port unified memory, one transaction outstanding.
// Define MEM_ARB_RR_EN for alternating priority on contention; default is fixed data-over-fetch priority.
module mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port (read only)
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   // data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   // memory port
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   logic [1:0] state;
   logic       owner;
   logic       pick_data;
   logic       accept;
   logic       resp;

`ifdef MEM_ARB_RR_EN
   // rr_fetch = 1: fetch wins the next contention
   logic rr_fetch;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_fetch <= 1'b1;
      end else if (accept) begin
         rr_fetch <= (owner == OWN_DATA);
      end
   end

   always_comb begin
      pick_data = d_req & (~if_req | ~rr_fetch);
   end
`else
   always_comb begin
      pick_data = d_req;
   end
`endif

   always_comb begin
      mem_valid = (state == ISSUE);
      accept    = mem_valid & mem_ready;
      resp      = (state == WAIT) & mem_rvalid;
      if_gnt    = accept & (owner == OWN_FETCH);
      d_gnt     = accept & (owner == OWN_DATA);
      if_rvalid = resp & (owner == OWN_FETCH);
      d_rvalid  = resp & (owner == OWN_DATA);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      // stores complete with a response pulse but carry no data back
      d_rdata   = (d_rvalid & ~mem_we) ? mem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_DATA;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req | d_req) begin
                  state     <= ISSUE;
                  owner     <= pick_data ? OWN_DATA : OWN_FETCH;
                  mem_we    <= pick_data & d_we;
                  mem_addr  <= pick_data ? d_addr : if_addr;
                  mem_wdata <= pick_data ? d_wdata : '0;
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention/reset sequences and a random run
// against a transaction-level reference model. Honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam logic [31:0] Z = 32'h0;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_valid, mem_we, mem_ready, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ir;
      logic [AW-1:0] ia;
      logic          dr;
      logic          dw;
      logic [AW-1:0] da;
      logic [DW-1:0] dd;
      logic          mr;
      logic          mv;
      logic [DW-1:0] md;
      logic          e_mv;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic          e_ig;
      logic          e_dg;
      logic          e_ir;
      logic [DW-1:0] e_ird;
      logic          e_dr;
      logic [DW-1:0] e_drd;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        input logic mr, input logic mv, input logic [DW-1:0] md);
      if_req = ir; if_addr = ia;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      mem_ready = mr; mem_rvalid = mv; mem_rdata = md;
   endtask

   task automatic expect_outs(input string tag, input logic e_mv, input logic e_we,
                              input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd,
                              input logic e_ig, input logic e_dg,
                              input logic e_ir, input logic [DW-1:0] e_ird,
                              input logic e_dr, input logic [DW-1:0] e_drd);
      chk({tag, " mem_valid"}, 64'(mem_valid), 64'(e_mv));
      if (e_mv) begin
         chk({tag, " mem_addr"}, 64'(mem_addr), 64'(e_addr));
         chk({tag, " mem_we"}, 64'(mem_we), 64'(e_we));
         if (e_we) chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(e_wd));
      end
      chk({tag, " if_gnt"}, 64'(if_gnt), 64'(e_ig));
      chk({tag, " d_gnt"}, 64'(d_gnt), 64'(e_dg));
      chk({tag, " if_rvalid"}, 64'(if_rvalid), 64'(e_ir));
      chk({tag, " if_rdata"}, 64'(if_rdata), 64'(e_ird));
      chk({tag, " d_rvalid"}, 64'(d_rvalid), 64'(e_dr));
      chk({tag, " d_rdata"}, 64'(d_rdata), 64'(e_drd));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(F, Z, F, F, Z, Z, F, F, Z);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Both requesters hold req high; memory answers one cycle after each accept.
   task automatic contention();
      int unsigned n = 0;
      int unsigned nrv = 0;
      int unsigned cyc = 0;
      int unsigned acc_c [4];
      int unsigned rv_c [4];
      logic [AW-1:0] order [4];
      logic [AW-1:0] exp_order [4];
      logic pend = 1'b0;
`ifdef MEM_ARB_RR_EN
      exp_order = '{32'h100, 32'h200, 32'h100, 32'h200};
`else
      exp_order = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
      while (n < 4 && cyc < 60) begin
         @(negedge clk);
         drive(T, 32'h100, T, F, 32'h200, Z, T, pend, 32'h77);
         #1;
         pend = 1'b0;
         if (mem_valid && mem_ready) begin
            order[n] = mem_addr; acc_c[n] = cyc; pend = 1'b1; n++;
         end
         if ((if_rvalid || d_rvalid) && nrv < 4) begin
            rv_c[nrv] = cyc; nrv++;
         end
         cyc++;
      end
      chk("contention accepts", 64'(n), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < int'(n)) chk($sformatf("contention order %0d", k), 64'(order[k]), 64'(exp_order[k]));
         if (k > 0 && k < int'(n) && k <= int'(nrv))
            chk($sformatf("contention idle gap %0d", k), 64'(acc_c[k]), 64'(rv_c[k-1] + 2));
      end
   endtask

   task automatic reset_in_wait();
      @(negedge clk); drive(T, 32'h80, F, F, Z, Z, F, F, Z);
      @(negedge clk); drive(T, 32'h80, F, F, Z, Z, T, F, Z);
      #1;
      chk("rst-wait accept", 64'(if_gnt), 64'd1);
      @(negedge clk); rst = 1'b1; drive(F, Z, F, F, Z, Z, F, F, Z);
      @(negedge clk); rst = 1'b0; drive(F, Z, F, F, Z, Z, F, T, 32'h99);
      #1;
      expect_outs("rst-wait late rvalid", F, F, Z, Z, F, F, F, Z, F, Z);
      chk("rst-wait mem_addr", 64'(mem_addr), 64'd0);
      chk("rst-wait mem_we", 64'(mem_we), 64'd0);
      @(negedge clk); drive(F, Z, T, F, 32'h300, Z, F, F, Z);
      #1;
      chk("rst-wait idle", 64'(mem_valid), 64'd0);
      @(negedge clk); drive(F, Z, T, F, 32'h300, Z, T, F, Z);
      #1;
      expect_outs("rst-wait recover", T, F, 32'h300, Z, F, T, F, Z, F, Z);
      @(negedge clk); drive(F, Z, F, F, Z, Z, F, T, 32'h5);
      #1;
      expect_outs("rst-wait recover resp", F, F, Z, Z, F, F, F, Z, T, 32'h5);
   endtask

   task automatic random_run();
      logic m_ir = 1'b0, m_dr = 1'b0, m_dw = 1'b0;
      logic [AW-1:0] m_ia = '0, m_da = '0;
      logic [DW-1:0] m_dd = '0, md;
      int ph = 0;                 // 0 free, 1 request presented to memory, 2 awaiting response
      logic own_d = 1'b1, c_we = 1'b0, ptr_f = 1'b1, win_d, mr, mv;
      logic [AW-1:0] c_addr = '0;
      logic [DW-1:0] c_wd = '0;
      int unsigned dly = 0;
      for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
         if (!m_ir && $urandom_range(2) == 0) begin m_ir = 1'b1; m_ia = $urandom; end
         if (!m_dr && $urandom_range(2) == 0) begin
            m_dr = 1'b1; m_dw = 1'($urandom_range(1)); m_da = $urandom; m_dd = $urandom;
         end
         mr = ($urandom_range(3) != 0);
         if (ph == 2) begin
            mv = (dly == 0);
            if (dly != 0) dly--;
         end else begin
            mv = ($urandom_range(9) == 0);
         end
         md = $urandom;
         @(negedge clk);
         drive(m_ir, m_ia, m_dr, m_dw, m_da, m_dd, mr, mv, md);
         #1;
         expect_outs("rand", ph == 1, c_we, c_addr, c_wd,
                     ph == 1 && mr && !own_d, ph == 1 && mr && own_d,
                     ph == 2 && mv && !own_d, (ph == 2 && mv && !own_d) ? md : Z,
                     ph == 2 && mv && own_d, (ph == 2 && mv && own_d && !c_we) ? md : Z);
         case (ph)
            0: if (m_ir || m_dr) begin
`ifdef MEM_ARB_RR_EN
                  win_d = m_dr && (!m_ir || !ptr_f);
`else
                  win_d = m_dr;
`endif
                  own_d = win_d; c_we = win_d && m_dw;
                  c_addr = win_d ? m_da : m_ia; c_wd = m_dd; ph = 1;
               end
            1: if (mr) begin
                  ph = 2; ptr_f = own_d; dly = $urandom_range(2);
                  if (own_d) m_dr = 1'b0; else m_ir = 1'b0;
               end
            default: if (mv) ph = 0;
         endcase
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(F, Z, F, F, Z, Z, F, F, Z);
      //           ir ia        dr dw da         dd            mr mv md           e_mv e_we e_addr   e_wd          ig dg ir ird      dr drd
      tbl[0]  = '{T, 32'h40,  F, F, Z,         Z,            F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[1]  = '{T, 32'h40,  F, F, Z,         Z,            T, F, Z,           T, F, 32'h40,    Z,            T, F, F, Z,       F, Z};
      tbl[2]  = '{F, Z,       F, F, Z,         Z,            F, F, 32'hAAAA,    F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[3]  = '{F, Z,       F, F, Z,         Z,            F, T, 32'h13,      F, F, Z,         Z,            F, F, T, 32'h13,  F, Z};
      tbl[4]  = '{F, Z,       F, F, Z,         Z,            F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[5]  = '{F, Z,       T, T, 32'h2000,  32'hDEADBEEF, F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[6]  = '{F, Z,       T, T, 32'h2000,  32'hDEADBEEF, F, F, Z,           T, T, 32'h2000,  32'hDEADBEEF, F, F, F, Z,       F, Z};
      tbl[7]  = '{F, Z,       T, T, 32'h3000,  Z,            F, F, Z,           T, T, 32'h2000,  32'hDEADBEEF, F, F, F, Z,       F, Z};
      tbl[8]  = '{F, Z,       T, T, 32'h2000,  32'hDEADBEEF, F, F, Z,           T, T, 32'h2000,  32'hDEADBEEF, F, F, F, Z,       F, Z};
      tbl[9]  = '{F, Z,       T, T, 32'h2000,  32'hDEADBEEF, T, F, Z,           T, T, 32'h2000,  32'hDEADBEEF, F, T, F, Z,       F, Z};
      tbl[10] = '{F, Z,       F, F, Z,         Z,            F, T, 32'h5555,    F, F, Z,         Z,            F, F, F, Z,       T, Z};
      tbl[11] = '{F, Z,       F, F, Z,         Z,            F, T, 32'h7777,    F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[12] = '{F, Z,       T, F, 32'h1000,  Z,            F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[13] = '{F, Z,       T, F, 32'h1000,  Z,            T, F, Z,           T, F, 32'h1000,  Z,            F, T, F, Z,       F, Z};
      tbl[14] = '{F, Z,       F, F, Z,         Z,            F, T, 32'hCAFE,    F, F, Z,         Z,            F, F, F, Z,       T, 32'hCAFE};
      tbl[15] = '{F, Z,       T, F, 32'h1100,  Z,            F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[16] = '{T, 32'h44,  T, F, 32'h1100,  Z,            T, F, Z,           T, F, 32'h1100,  Z,            F, T, F, Z,       F, Z};
      tbl[17] = '{F, Z,       F, F, Z,         Z,            F, T, 32'h1,       F, F, Z,         Z,            F, F, F, Z,       T, 32'h1};
      tbl[18] = '{F, Z,       F, F, Z,         Z,            F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};
      tbl[19] = '{F, Z,       F, F, Z,         Z,            F, F, Z,           F, F, Z,         Z,            F, F, F, Z,       F, Z};

      do_reset();
      @(negedge clk);
      drive(F, Z, F, F, Z, Z, F, F, Z);
      #1;
      expect_outs("reset", F, F, Z, Z, F, F, F, Z, F, Z);
      chk("reset mem_addr", 64'(mem_addr), 64'd0);
      chk("reset mem_we", 64'(mem_we), 64'd0);
      chk("reset mem_wdata", 64'(mem_wdata), 64'd0);

      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         drive(tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].da, tbl[k].dd,
               tbl[k].mr, tbl[k].mv, tbl[k].md);
         #1;
         expect_outs($sformatf("vec%0d", k), tbl[k].e_mv, tbl[k].e_we, tbl[k].e_addr, tbl[k].e_wd,
                     tbl[k].e_ig, tbl[k].e_dg, tbl[k].e_ir, tbl[k].e_ird, tbl[k].e_dr, tbl[k].e_drd);
      end

      do_reset();
      contention();
      do_reset();
      reset_in_wait();
      do_reset();
      random_run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 64, data width of both requesters and the memory port.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction-fetch request and address (fetch is always a read).
REQ-006 SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W: fetch accept pulse, response pulse, read data.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W: data-port request, 1 = store, address, store data.
REQ-008 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W: data accept pulse, response pulse, load data.
REQ-009 SHALL have ports mem_valid out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_ready in 1: request to the single-port unified memory.
REQ-010 SHALL have ports mem_rvalid in 1, mem_rdata in DATA_W: memory response, one pulse per accepted request, including stores.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-012 In IDLE with any request, SHALL select a winner, register its we/addr/wdata and owner, and enter ISSUE next cycle.
REQ-013 Arbitration (macro absent): data port SHALL win when d_req and if_req are both high in the same IDLE cycle.
REQ-014 In ISSUE, mem_valid SHALL be 1 with registered mem_we/mem_addr/mem_wdata held stable until the cycle mem_valid & mem_ready.
REQ-015 In the accept cycle, the owner's gnt SHALL pulse high for exactly one cycle; FSM SHALL enter WAIT.
REQ-016 Requesters SHALL hold req and payload stable until their gnt; the arbiter SHALL ignore payload changes after capture.
REQ-017 In WAIT, on mem_rvalid, the owner's rvalid SHALL pulse one cycle with rdata = mem_rdata (store: rdata = 0); FSM SHALL return to IDLE.
REQ-018 Non-owner rvalid/gnt SHALL stay 0; non-owner rdata SHALL be 0.
REQ-019 Minimum latency: req sampled cycle N -> mem_valid cycle N+1 -> gnt N+1 (mem_ready=1) -> rvalid in mem_rvalid cycle (>= N+2).
REQ-020 A request dropped before capture in IDLE SHALL not be issued; after capture it SHALL complete regardless of req.
REQ-021 mem_rvalid outside WAIT SHALL be ignored (no rvalid to any requester).
REQ-022 Back-to-back: a request pending in the cycle FSM returns to IDLE SHALL be captured in that IDLE cycle (one idle cycle between transactions).
REQ-023 mem_valid SHALL be 0 in IDLE and WAIT.

Reset
REQ-024 On rst: FSM = IDLE; mem_valid, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; owner = data; RR pointer = fetch-first.
REQ-025 rst asserted in ISSUE or WAIT SHALL abort the transaction; its later mem_rvalid SHALL be ignored per REQ-021.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: on simultaneous requests, winner SHALL alternate; priority pointer SHALL flip to the other port after every grant; first contention after reset SHALL go to fetch.
REQ-027 Macro MEM_ARB_RR_EN absent: fixed data-over-fetch priority per REQ-013; no pointer state.

Verification
REQ-028 Fetch only: if_req=1, if_addr=0x40, mem_ready=1, mem_rvalid 2 cycles after accept with 0x00000013 -> mem_valid 1 cycle, if_gnt 1 cycle, if_rvalid=1 with if_rdata=0x13.
REQ-029 Contention, no macro: if_req and d_req (load 0x1000) same cycle -> data issued first; fetch issued after data d_rvalid + 1 idle cycle.
REQ-030 Contention, MEM_ARB_RR_EN: both held high for 4 transactions -> issue order fetch, data, fetch, data.
REQ-031 Backpressure: d store addr 0x2000 wdata 0xDEADBEEF, mem_ready=0 for 3 cycles -> mem_valid/addr/wdata stable 4 cycles, d_gnt only on cycle 4, d_rvalid with d_rdata=0.
REQ-032 Reset in WAIT: rst 1 cycle then mem_rvalid=1 -> no if_rvalid/d_rvalid, FSM IDLE, all outputs 0.
